// File: rtl/checkbits_frame_tx.sv
// checkbits_frame_tx
//   Transmit side of the mprj_io[31:16] "checkbits" monitor protocol. A frame
//   is a START_MARK, the data words taken from a valid/ready stream, then an
//   END_MARK. Each value is held for HOLD_CYCLES clocks so that an off-chip
//   per-clock equality monitor can sample it and measure latency.
//
//   Optional build macro: CHECKBITS_GAP_EN
//     When defined, IDLE_VAL is driven for HOLD_CYCLES after every data word.
//     Equal adjacent words can then be counted separately. When undefined,
//     DATA goes straight to WAIT/END.
//
// Ports
//   wb_clk_i     in   1   system clock
//   wb_rst_i     in   1   asynchronous reset, active high
//   frame_start  in   1   pulse that opens a frame; ignored unless idle
//   s_tvalid     in   1   data word valid
//   s_tdata      in   16  data word
//   s_tlast      in   1   last word of the frame
//   s_tready     out  1   word accepted on s_tvalid && s_tready
//   chk_o        out  16  value driven to the pads
//   chk_oeb      out  16  pad output enable, active low (always driving)
//   busy         out  1   high in any state except IDLE
//   frame_done   out  1   one-cycle pulse when END returns to IDLE
//   frame_cnt    out  8   completed frames, wraps 255 -> 0
//   collision    out  1   sticky: a data word equalled one of the markers
module checkbits_frame_tx #(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] START_MARK  = 16'h00A5,
    parameter logic [15:0] END_MARK    = 16'h765A,
    parameter logic [15:0] IDLE_VAL    = 16'h0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        frame_start,
    input  logic        s_tvalid,
    input  logic [15:0] s_tdata,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [15:0] chk_o,
    output logic [15:0] chk_oeb,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        collision
);

    // Hold counter is at least one bit wide so HOLD_CYCLES=1 still elaborates.
    localparam int             HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  HCNT_ONE  = HW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DATA  = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   hcnt_reg;
    logic            last_reg;
    logic            hold_done;

    assign hold_done = (hcnt_reg == '0);

    // The pads are always outputs.
    assign chk_oeb = 16'h0000;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg  <= S_IDLE;
            hcnt_reg   <= '0;
            last_reg   <= 1'b0;
            chk_o      <= IDLE_VAL;
            s_tready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            collision  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (hcnt_reg != '0) begin
                hcnt_reg <= hcnt_reg - HCNT_ONE;
            end

            case (state_reg)
                S_IDLE: begin
                    // chk_o keeps whatever was last driven (END_MARK after a frame).
                    if (frame_start) begin
                        state_reg <= S_START;
                        chk_o     <= START_MARK;
                        hcnt_reg  <= HOLD_LOAD;
                        busy      <= 1'b1;
                    end
                end

                S_START: begin
                    if (hold_done) begin
                        state_reg <= S_WAIT;
                        s_tready  <= 1'b1;
                    end
                end

                S_WAIT: begin
                    // chk_o keeps the previous value while the source is stalled.
                    if (s_tvalid && s_tready) begin
                        state_reg <= S_DATA;
                        chk_o     <= s_tdata;
                        last_reg  <= s_tlast;
                        hcnt_reg  <= HOLD_LOAD;
                        s_tready  <= 1'b0;
                        if ((s_tdata == START_MARK) || (s_tdata == END_MARK)) begin
                            collision <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (hold_done) begin
`ifdef CHECKBITS_GAP_EN
                        state_reg <= S_GAP;
                        chk_o     <= IDLE_VAL;
                        hcnt_reg  <= HOLD_LOAD;
`else
                        if (last_reg) begin
                            state_reg <= S_END;
                            chk_o     <= END_MARK;
                            hcnt_reg  <= HOLD_LOAD;
                        end else begin
                            state_reg <= S_WAIT;
                            s_tready  <= 1'b1;
                        end
`endif
                    end
                end

`ifdef CHECKBITS_GAP_EN
                S_GAP: begin
                    if (hold_done) begin
                        if (last_reg) begin
                            state_reg <= S_END;
                            chk_o     <= END_MARK;
                            hcnt_reg  <= HOLD_LOAD;
                        end else begin
                            state_reg <= S_WAIT;
                            s_tready  <= 1'b1;
                        end
                    end
                end
`endif

                S_END: begin
                    if (hold_done) begin
                        state_reg  <= S_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    s_tready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checkbits_frame_tx.sv
// Self-checking bench for checkbits_frame_tx. A scoreboard holds the expected
// sequence of values (runs) on chk_o; a monitor pops and compares one entry
// every time chk_o changes, and checks run lengths where they are known.
module tb_checkbits_frame_tx;

    localparam int          H          = 4;
    localparam logic [15:0] START_MARK = 16'h00A5;
    localparam logic [15:0] END_MARK   = 16'h765A;
    localparam logic [15:0] IDLE_VAL   = 16'h0000;
`ifdef CHECKBITS_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        frame_start = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_tdata = 16'h0000;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] chk_o;
    logic [15:0] chk_oeb;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        collision;

    checkbits_frame_tx #(
        .HOLD_CYCLES (H),
        .START_MARK  (START_MARK),
        .END_MARK    (END_MARK),
        .IDLE_VAL    (IDLE_VAL)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .frame_start (frame_start),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .chk_o       (chk_o),
        .chk_oeb     (chk_oeb),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected chk_o runs; len 0 means the length is not checked.
    typedef struct {
        logic [15:0] val;
        int          len;
    } run_t;

    run_t        sb[$];
    logic [15:0] tx_words[$];
    bit          mon_en   = 1'b0;
    logic [15:0] cur_val  = IDLE_VAL;
    int          cur_len  = 0;
    int          cur_exp  = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_frames = 8'd0;
    int          exp_done = 0;
    int          frame_no = 0;

    // Equal adjacent values merge into one run, as the pad monitor sees them.
    task automatic sb_push(input logic [15:0] v, input int len);
        run_t t;
        if (sb.size() > 0 && sb[$].val == v) begin
            t = sb.pop_back();
            t.len = (t.len == 0 || len == 0) ? 0 : t.len + len;
            sb.push_back(t);
        end else begin
            t.val = v;
            t.len = len;
            sb.push_back(t);
        end
    endtask

    // Expected runs for tx_words with s_tvalid effectively stuck high:
    // START is seen for H cycles plus the first WAIT cycle; every value that
    // is followed by WAIT gains that one cycle too.
    task automatic frame_model(input bit exact);
        int n;
        bit last;
        n = tx_words.size();
        sb_push(START_MARK, exact ? H + 1 : 0);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            if (GAP_EN) begin
                sb_push(tx_words[i], exact ? H : 0);
                sb_push(IDLE_VAL, exact ? (last ? H : H + 1) : 0);
            end else begin
                sb_push(tx_words[i], exact ? (last ? H : H + 1) : 0);
            end
        end
        sb_push(END_MARK, 0);
    endtask

    always @(negedge clk) begin
        run_t e;
        if (mon_en) begin
            if (chk_o !== cur_val) begin
                if (cur_exp != 0) check_val("run_len", 32'(cur_len), 32'(cur_exp));
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'(sb.size()), 32'd1);
                    cur_exp = 0;
                end else begin
                    e = sb.pop_front();
                    check_val("run_val", {16'h0, chk_o}, {16'h0, e.val});
                    cur_exp = e.len;
                end
                cur_val = chk_o;
                cur_len = 1;
            end else begin
                cur_len++;
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_tready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_val("tready_timeout", {31'h0, s_tready}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check_val("busy_timeout", {31'h0, busy}, 32'd0);
    endtask

    // Sends tx_words as one frame. gap>0 stalls s_tvalid that many cycles
    // in WAIT before each word; poke pulses frame_start during DATA.
    task automatic send_frame(input int gap, input bit exact, input bit poke);
        int n;
        n = tx_words.size();
        frame_model(exact);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check_val("busy_high", {31'h0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) begin
                wait_ready();
                repeat (gap) begin
                    check_val("tready_gap", {31'h0, s_tready}, 32'd1);
                    @(posedge clk); #1;
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = tx_words[i];
            s_tlast  = (i == n - 1);
            wait_ready();
            @(posedge clk); #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            if (poke && i == 0) begin
                frame_start = 1'b1;
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        end
        wait_idle();
        @(posedge clk); #1;
        exp_frames = exp_frames + 8'd1;
        exp_done++;
        frame_no++;
        check_val("frame_cnt", {24'h0, frame_cnt}, {24'h0, exp_frames});
        check_val("frame_done_cnt", 32'(done_cnt), 32'(exp_done));
        $display("frame %0d words=%0d gap=%0d frame_cnt=%0d collision=%0b",
                 frame_no, n, gap, frame_cnt, collision);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_chk_o", {16'h0, chk_o}, {16'h0, IDLE_VAL});
        check_val("rst_chk_oeb", {16'h0, chk_oeb}, 32'h0);
        check_val("rst_tready", {31'h0, s_tready}, 32'd0);
        check_val("rst_busy", {31'h0, busy}, 32'd0);
        check_val("rst_frame_done", {31'h0, frame_done}, 32'd0);
        check_val("rst_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        check_val("rst_collision", {31'h0, collision}, 32'd0);
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back three-word frame
        tx_words = '{16'h0001, 16'h0002, 16'h0003};
        send_frame(0, 1'b1, 1'b0);
        check_val("no_collision", {31'h0, collision}, 32'd0);

        // Source stalls in WAIT between words
        tx_words = '{16'h0010, 16'h0020, 16'h0030};
        send_frame(10, 1'b0, 1'b0);

        // A data word equal to END_MARK mid-frame
        tx_words = '{16'h0100, END_MARK, 16'h0200};
        send_frame(0, 1'b1, 1'b0);
        check_val("collision_set", {31'h0, collision}, 32'd1);
        tx_words = '{16'h0007};
        send_frame(0, 1'b1, 1'b0);
        check_val("collision_sticky", {31'h0, collision}, 32'd1);

        // frame_start during DATA is ignored
        tx_words = '{16'h000A, 16'h000B};
        send_frame(0, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check_val("poke_busy", {31'h0, busy}, 32'd0);
        check_val("poke_frame_cnt", {24'h0, frame_cnt}, {24'h0, exp_frames});

        // Asynchronous reset in the middle of DATA
        sb_push(START_MARK, H + 1);
        sb_push(16'h1111, 0);
        sb_push(IDLE_VAL, 0);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 16'h1111;
        s_tlast  = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check_val("async_chk_o", {16'h0, chk_o}, {16'h0, IDLE_VAL});
        check_val("async_busy", {31'h0, busy}, 32'd0);
        check_val("async_tready", {31'h0, s_tready}, 32'd0);
        check_val("async_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        check_val("async_collision", {31'h0, collision}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        exp_frames = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_no_done", 32'(done_cnt), 32'(exp_done));
        check_val("rst_chk_hold", {16'h0, chk_o}, {16'h0, IDLE_VAL});
        $display("reset mid-frame frame_cnt=%0d", frame_cnt);

        // Equal adjacent words
        tx_words = '{16'h0005, 16'h0005};
        send_frame(0, 1'b1, 1'b0);

        // One-word frames until frame_cnt wraps to 0
        for (int k = 0; k < 255; k++) begin
            tx_words = '{16'h1000 + 16'(k)};
            send_frame(0, 1'b1, 1'b0);
        end
        check_val("wrap_frame_cnt", {24'h0, frame_cnt}, 32'd0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
